// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: instruction field slices, opcodes and fetch FSM encoding.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int TARGET_MSB = 25;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC select (sequential, taken branch, jump).
// Jump support is compiled in only when IFU_JUMP_EN is defined.
module ifu_next_pc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               zero,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [ADDR_W-1:0]  next_pc
);

`ifdef IFU_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic              is_jump_s;

  // Candidate targets and priority select: jump over taken branch over sequential.
  always_comb begin
    pc_plus4   = pc + ADDR_W'(32'd4);
    br_off_s   = {{(ADDR_W-18){instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
    jump_tgt_s = {pc_plus4[ADDR_W-1:28], instr[TARGET_MSB:0], 2'b00};
    is_jump_s  = JUMP_EN & (instr[OPCODE_MSB:OPCODE_LSB] == OP_J);
    if (is_jump_s) begin
      next_pc = jump_tgt_s;
    end else if (branch & zero) begin
      next_pc = pc_plus4 + br_off_s;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register and FETCH/WAIT/HOLD handshake FSM in front of decode.
// Build option IFU_JUMP_EN enables j-instruction redirect inside ifu_next_pc.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               Branch,
  input  logic               Zero,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         Opcode,
  output logic [5:0]         Func,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [31:0]        instr_count,
  output logic               proto_err
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        count_q, count_d;
  logic               proto_err_q, proto_err_d;
  logic [ADDR_W-1:0]  next_pc_s;

  ifu_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q),
    .branch   (Branch),
    .zero     (Zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc_s)
  );

  // Handshake FSM; Branch/Zero only matter through next_pc_s on the HOLD ack cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (instr_ack) begin
          pc_d    = next_pc_s;
          count_d = count_q + 32'd1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // A response is legal only while waiting; anything else is dropped and flagged until reset.
  always_comb begin
    if (imem_valid && (state_q != ST_WAIT)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= {INSTR_W{1'b0}};
      count_q     <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH) & ~rst;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign Opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign Func        = instr_q[FUNC_MSB:FUNC_LSB];
  assign pc_out      = pc_q;
  assign instr_count = count_q;
  assign proto_err   = proto_err_q;

endmodule
